// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, framing constants and the
// baud divider helper used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    // Clocks per oversample tick, truncated; callers must keep this >= 2.
    function automatic int tick_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: single-cycle tick every TICK_DIV clocks,
// held at zero while clear is high so a frame always starts phase-aligned.
module baud_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign tick = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, a one-byte holding register on a
// valid/ready handshake, and single-cycle framing-error / overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int TICK_DIV = tick_div(CLK_HZ, BAUD);
    localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

    rx_state_t  r_state, w_stateNext;
    logic       r_rxMeta, r_rxSync;
    logic [3:0] r_sampleCnt;
    logic [2:0] r_bitIdx;
    logic [7:0] r_shift;
    logic [7:0] r_dataOut;
    logic       r_rxValid, r_framingError, r_overrun;

    logic w_tick, w_tickClear;
    logic w_cntClear, w_shiftEn, w_stopOk, w_stopBad;

    assign w_tickClear = (r_state == IDLE);

    baud_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .enable(1'b1),
        .clear (w_tickClear),
        .tick  (w_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntClear  = 1'b0;
        w_shiftEn   = 1'b0;
        w_stopOk    = 1'b0;
        w_stopBad   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rxSync) begin
                    w_stateNext = START;
                    w_cntClear  = 1'b1;
                end
            end
            START: begin
                if (w_tick && r_sampleCnt == MID_LAST) begin
                    w_cntClear  = 1'b1;
                    w_stateNext = r_rxSync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick && r_sampleCnt == BIT_LAST) begin
                    w_shiftEn = 1'b1;
                    if (r_bitIdx == IDX_LAST) begin
                        w_stateNext = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick && r_sampleCnt == BIT_LAST) begin
                    w_stopOk    = r_rxSync;
                    w_stopBad   = !r_rxSync;
                    w_stateNext = r_rxSync ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (r_rxSync) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // A finished byte either fills the holding register (when it is empty or
    // being drained this cycle) or is dropped with an overrun pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rxMeta       <= 1'b1;
            r_rxSync       <= 1'b1;
            r_sampleCnt    <= '0;
            r_bitIdx       <= '0;
            r_shift        <= '0;
            r_dataOut      <= '0;
            r_rxValid      <= 1'b0;
            r_framingError <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_rxMeta       <= rx;
            r_rxSync       <= r_rxMeta;
            r_framingError <= w_stopBad;
            r_overrun      <= 1'b0;
            if (w_cntClear) begin
                r_sampleCnt <= '0;
            end else if (w_tick) begin
                r_sampleCnt <= r_sampleCnt + 4'd1;
            end
            if (w_cntClear) begin
                r_bitIdx <= '0;
            end else if (w_shiftEn) begin
                r_bitIdx <= r_bitIdx + 3'd1;
            end
            if (w_shiftEn) begin
                r_shift <= {r_rxSync, r_shift[7:1]};
            end
            if (w_stopOk) begin
                if (!r_rxValid || rx_ready) begin
                    r_dataOut <= r_shift;
                    r_rxValid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rxValid && rx_ready) begin
                r_rxValid <= 1'b0;
            end
        end
    end

    assign data_out      = r_dataOut;
    assign rx_valid      = r_rxValid;
    assign framing_error = r_framingError;
    assign overrun       = r_overrun;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 1.6 MHz / 10 kBd (160 clocks per bit).
module tb_uart_receiver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    localparam int BIT_CLKS = 160;

    uart_receiver #(.CLK_HZ(1_600_000), .BAUD(10_000)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .data_out     (data_out),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .framing_error(framing_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    int cycle = 0;
    int nFe = 0;
    int nOv = 0;
    int nBoth = 0;
    int nValidCycles = 0;
    int validRise = 0;
    logic prevValid = 1'b0;
    logic [7:0] accepted[$];

    // Event recorder, sampled on the falling edge away from input changes.
    always @(negedge clock) begin
        cycle++;
        if (rx_valid && rx_ready) accepted.push_back(data_out);
        if (rx_valid) nValidCycles++;
        if (framing_error) nFe++;
        if (overrun) nOv++;
        if (framing_error && overrun) nBoth++;
        if (rx_valid && !prevValid) validRise = cycle;
        prevValid = rx_valid;
    end

    task automatic waitClocks(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One 8N1 frame; the line is left at the stop level afterwards.
    task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
        rx = 1'b0;
        waitClocks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = value[i];
            waitClocks(BIT_CLKS);
        end
        rx = stopBit;
        waitClocks(BIT_CLKS);
    endtask

    function automatic logic [31:0] lastAccepted();
        if (accepted.size() == 0) return 32'hFFFF_FFFF;
        return {24'd0, accepted[accepted.size() - 1]};
    endfunction

    logic [7:0] msg [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    initial begin
        int accBase, feBase, ovBase, vcBase, startCycle, lat;
        logic [31:0] obs;

        $display("[TB] start");
        waitClocks(4);
        checkOutput("rst_data_out", {24'd0, data_out}, 32'h00);
        checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rst_framing_error", {31'd0, framing_error}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        waitClocks(10);

        // Scenario 1: single byte, consumer always ready.
        rx_ready = 1'b1;
        accBase = accepted.size(); feBase = nFe; ovBase = nOv; vcBase = nValidCycles;
        startCycle = cycle;
        applyStimulus(8'h48, 1'b1);
        waitClocks(20);
        lat = validRise - startCycle;
        checkOutput("s1_count", accepted.size() - accBase, 32'd1);
        checkOutput("s1_data", lastAccepted(), 32'h48);
        checkOutput("s1_valid_width", nValidCycles - vcBase, 32'd1);
        checks++;
        assert (lat >= 1515 && lat <= 1530) else begin
            failures++;
            $error("[TB] FAIL s1_latency observed=%0d expected=1515..1530", lat);
        end
        checkOutput("s1_fe", nFe - feBase, 32'd0);
        checkOutput("s1_ov", nOv - ovBase, 32'd0);
        checkOutput("s1_busy_idle", {31'd0, busy}, 32'd0);

        // Scenario 2: back-to-back bytes with the consumer stalled.
        rx_ready = 1'b0;
        accBase = accepted.size(); feBase = nFe; ovBase = nOv;
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'hAA, 1'b1);
        waitClocks(20);
        checkOutput("s2_valid_held", {31'd0, rx_valid}, 32'd1);
        checkOutput("s2_data_held", {24'd0, data_out}, 32'h55);
        checkOutput("s2_overrun_once", nOv - ovBase, 32'd1);
        checkOutput("s2_no_fe", nFe - feBase, 32'd0);
        rx_ready = 1'b1;
        checkOutput("s2_valid_before_accept", {31'd0, rx_valid}, 32'd1);
        waitClocks(1);
        checkOutput("s2_valid_falls", {31'd0, rx_valid}, 32'd0);
        checkOutput("s2_accept_count", accepted.size() - accBase, 32'd1);
        checkOutput("s2_accept_data", lastAccepted(), 32'h55);

        // Scenario 3: bad stop bit followed by a held-low line.
        accBase = accepted.size(); feBase = nFe; ovBase = nOv; vcBase = nValidCycles;
        applyStimulus(8'h41, 1'b0);
        waitClocks(3 * BIT_CLKS);
        checkOutput("s3_fe_once", nFe - feBase, 32'd1);
        checkOutput("s3_no_valid", nValidCycles - vcBase, 32'd0);
        checkOutput("s3_busy_in_break", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        waitClocks(2 * BIT_CLKS);
        applyStimulus(8'h42, 1'b1);
        waitClocks(20);
        checkOutput("s3_recover_count", accepted.size() - accBase, 32'd1);
        checkOutput("s3_recover_data", lastAccepted(), 32'h42);
        checkOutput("s3_fe_total", nFe - feBase, 32'd1);
        checkOutput("s3_no_ov", nOv - ovBase, 32'd0);

        // Scenario 4: short low glitch while idle.
        vcBase = nValidCycles; feBase = nFe; ovBase = nOv;
        rx = 1'b0;
        waitClocks(10);
        checkOutput("s4_busy_during_start", {31'd0, busy}, 32'd1);
        waitClocks(40);
        rx = 1'b1;
        waitClocks(100);
        checkOutput("s4_busy_back_idle", {31'd0, busy}, 32'd0);
        checkOutput("s4_no_valid", nValidCycles - vcBase, 32'd0);
        checkOutput("s4_no_errors", (nFe - feBase) + (nOv - ovBase), 32'd0);

        // Scenario 5: reset in the middle of bit 4.
        accBase = accepted.size(); vcBase = nValidCycles;
        rx = 1'b0;
        waitClocks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            waitClocks(BIT_CLKS);
        end
        rx = 1'b1;
        waitClocks(BIT_CLKS / 2);
        reset = 1'b1;
        waitClocks(2);
        checkOutput("s5_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("s5_rst_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("s5_rst_data", {24'd0, data_out}, 32'h00);
        reset = 1'b0;
        waitClocks(2 * BIT_CLKS);
        checkOutput("s5_no_partial", nValidCycles - vcBase, 32'd0);
        applyStimulus(8'h0D, 1'b1);
        waitClocks(20);
        checkOutput("s5_count", accepted.size() - accBase, 32'd1);
        checkOutput("s5_data", lastAccepted(), 32'h0D);

        // Scenario 6: continuous stream.
        accBase = accepted.size(); feBase = nFe; ovBase = nOv;
        for (int i = 0; i < 14; i++) applyStimulus(msg[i], 1'b1);
        waitClocks(20);
        checkOutput("s6_count", accepted.size() - accBase, 32'd14);
        for (int i = 0; i < 14; i++) begin
            obs = (accBase + i < accepted.size()) ? {24'd0, accepted[accBase + i]} : 32'hFFFF_FFFF;
            checkOutput($sformatf("s6_byte%0d", i), obs, {24'd0, msg[i]});
        end
        checkOutput("s6_no_errors", (nFe - feBase) + (nOv - ovBase), 32'd0);
        checkOutput("never_fe_and_ov", nBoth, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
